uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Byte FIFO between the core's memory-mapped UART data-register write and the UART transmitter. It accepts bytes on a single-cycle write strobe from the load/store path, holds them in order, and presents the head byte with a valid/ready handshake to the transmit controller. The controller loads that byte into its data register and shift register. The block decouples core stores from the slow serial bit rate, so software can queue up to DEPTH bytes without polling per byte.

## Interface
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en_i  input  1  one-cycle write strobe from the core's store to the UART data register.
- wr_data_i  input  8  byte to enqueue; sampled when wr_en_i=1.
- tx_data_o  output  8  head byte; drives the transmitter's parallel data input.
- tx_valid_o  output  1  head byte present (FIFO not empty).
- tx_ready_i  input  1  transmit controller is idle and takes the head byte this cycle.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- count_o  output  AW+1  number of stored bytes, 0..DEPTH.
- clear_ovf_i  input  1  clears the overflow flag.
- overflow_o  output  1  sticky flag: a write was dropped.

## Operation
- Storage: DEPTH x 8 register array, write pointer wp, read pointer rp, each AW bits. Pointers wrap modulo DEPTH. count is held in a separate AW+1-bit register.
- Push: wr_en_i=1 and (count<DEPTH or pop this cycle). The byte is written at wp and wp increments.
- Pop: tx_valid_o=1 and tx_ready_i=1. rp increments. tx_ready_i while empty is ignored.
- Count update:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged
- Full and write without pop: the byte is dropped, pointers and count are unchanged, and the overflow event fires.
- Full and write with pop in the same cycle: the write is accepted and count stays DEPTH.
- Empty and write: the byte is stored. No same-cycle pass-through.
- tx_data_o = mem[rp], first-word-fall-through. When empty, tx_data_o holds the last array content at rp and is don't-care.
- tx_valid_o = !empty_o. empty_o, full_o and count_o are decoded from the count register, not from pointer compare.
- Overflow flag:
  - sets on a dropped write
  - clears on clear_ovf_i=1
  - if set and clear occur in the same cycle, set wins
- Reset (asynchronous, any time including mid-transfer): wp=0, rp=0, count=0, overflow=0. Array contents are not cleared.
- Reset values: tx_valid_o=0, empty_o=1, full_o=0, count_o=0, overflow_o=0. A byte already handed to the transmitter is unaffected here; the transmitter has its own reset.

## Timing
- Write on edge N: count_o, empty_o and tx_valid_o reflect it after edge N. The earliest pop is at edge N+1. Write-to-valid latency is 1 cycle.
- Pop on edge N: the next head appears on tx_data_o after edge N, so back-to-back pops are allowed every cycle.
- tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- full_o, count_o and overflow_o update only on clock edges (all registered), except during asynchronous reset assertion.

## Configuration
- UART_TX_BUF_OVF_EN
  - Defined: overflow_o is the sticky flag described above, and clear_ovf_i is honoured.
  - Undefined: the overflow register is not built, overflow_o is tied to 0, and clear_ovf_i is ignored.
  - Dropped-write behaviour on full is identical in both builds.

## Test plan
- Reset then idle: release reset, hold tx_ready_i=1 -> empty_o=1, tx_valid_o=0, count_o=0, overflow_o=0 for 10 cycles.
- Ordering: write 0x55, 0xA3, 0x0F on consecutive cycles with tx_ready_i=0 -> count_o=3, tx_data_o=0x55. Then tx_ready_i=1 for 3 cycles -> tx_data_o sequence 0x55, 0xA3, 0x0F, then empty_o=1.
- Full and overflow (DEPTH=16):
  - Write 0x00..0x0F, then write 0xEE -> full_o=1, count_o=16, overflow_o=1 (OVF_EN build) or 0 (non-OVF build).
  - Drain -> 0x00..0x0F exactly, 0xEE never appears.
  - Pulse clear_ovf_i -> overflow_o=0.
- Simultaneous push/pop at full: with the FIFO full, write 0x77 with tx_ready_i=1 -> count_o stays 16, overflow_o=0, and 0x77 is the last byte drained.
- Wrap-around: 40 bytes streamed, write and pop every cycle from count=1 -> output sequence equals input sequence, count_o=1 throughout.
- Async reset mid-operation: with count_o=5, assert reset_i=0 between clock edges -> tx_valid_o=0 and count_o=0 immediately. Release, write 0x3C -> tx_data_o=0x3C, count_o=1.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// ---------------------------------------------------------------------------
// Byte FIFO between the core's memory-mapped UART data-register store and the
// UART transmit controller. Bytes arrive on a one-cycle write strobe. They are
// held in order. The head byte is presented first-word-fall-through with a
// valid/ready handshake. Software can therefore queue up to DEPTH bytes
// without polling for each byte.
//
// Parameters
//   DEPTH        number of byte entries (power of two, >= 2)
//   AW           pointer width, $clog2(DEPTH) (derived)
//
// Ports
//   clk_i        clock, rising-edge active
//   reset_i      asynchronous active-low reset
//   wr_en_i      one-cycle write strobe
//   wr_data_i    byte to enqueue
//   tx_data_o    head byte (don't-care while empty)
//   tx_valid_o   head byte present
//   tx_ready_i   transmitter takes the head byte this cycle
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      number of stored bytes, 0..DEPTH
//   clear_ovf_i  clears the sticky overflow flag
//   overflow_o   sticky flag: a write was dropped because the FIFO was full
//
// Build option
//   UART_TX_BUF_OVF_EN  when defined, the sticky overflow flag is built and
//                       clear_ovf_i is honoured. When undefined, overflow_o
//                       is tied to 0. Writes to a full FIFO are dropped in
//                       both builds.
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  input  logic          clear_ovf_i,
  output logic          overflow_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   count_reg;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Status comes from the count register and not from a pointer compare.
  // At count == DEPTH the two pointers are equal, the same as at count == 0.
  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  assign pop  = !empty && tx_ready_i;
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign push = wr_en_i && (!full || pop);
  assign drop = wr_en_i && full && !pop;

  // Storage array. It has no reset, so the contents survive reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wp_reg] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (pop) begin
        rp_reg <= rp_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Head byte falls through as soon as it is stored.
  // A write into an empty FIFO becomes visible only after the clock edge.
  assign tx_data_o  = mem[rp_reg];
  assign tx_valid_o = !empty;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_reg;

`ifdef UART_TX_BUF_OVF_EN
  logic ovf_reg;

  // When a drop and a clear happen in the same cycle, the set wins.
  // The drop is then not lost.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (clear_ovf_i) begin
      ovf_reg <= 1'b0;
    end
  end

  assign overflow_o = ovf_reg;
`else
  logic unused_ovf;
  assign unused_ovf = clear_ovf_i ^ drop;
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer.
// The reference model is a byte queue with the FIFO's acceptance rules.
// Accepted bytes also go into a scoreboard queue. A monitor pops that queue
// on every DUT handshake and compares the byte.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [7:0]    wr_data_i = 8'h00;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          clear_ovf_i = 1'b0;
  logic          overflow_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];   // model FIFO contents
  logic [7:0] sb_q[$];  // scoreboard: bytes the DUT must hand out, in order
  bit         m_ovf = 1'b0;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .clear_ovf_i(clear_ovf_i),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge.
  // 1. Check the DUT state against the model.
  // 2. Drive one cycle of inputs.
  // 3. Advance the model by that cycle.
  task automatic step(input bit wr, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop;
    bit push;
    bit drop;
    int n;
    n = m_q.size();
    chk("count", int'(count_o), n);
    chk("empty", int'(empty_o), int'(n == 0));
    chk("full", int'(full_o), int'(n == DEPTH));
    chk("valid", int'(tx_valid_o), int'(n != 0));
    chk("overflow", int'(overflow_o), int'(m_ovf));
    if (n != 0) chk("head", int'(tx_data_o), int'(m_q[0]));

    wr_en_i     = wr;
    wr_data_i   = d;
    tx_ready_i  = rdy;
    clear_ovf_i = clr;

    pop  = (n != 0) && rdy;
    push = wr && ((n < DEPTH) || pop);
    drop = wr && !push;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(d);
      sb_q.push_back(d);
    end
`ifdef UART_TX_BUF_OVF_EN
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
`else
    m_ovf = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: samples well before the rising edge on which the handshake
  // takes effect.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (reset_i && tx_valid_o && tx_ready_i) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got=%02h want=none", tx_data_o);
        end else begin
          exp = sb_q.pop_front();
          if (tx_data_o !== exp) begin
            bad++;
            $display("FAIL pop_data: got=%02h want=%02h", tx_data_o, exp);
          end else begin
            $display("pop data=%02h ok", tx_data_o);
          end
        end
      end
    end
  end

  initial begin
    int r;
    int pw;
    int pr;
    // Power-on reset.
    repeat (2) @(negedge clk);
    reset_i = 1'b1;

    // Idle with ready high.
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Ordering.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow, drain, clear.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    drain();

    // Wrap-around streaming at count 1.
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    drain();

    // Asynchronous reset while holding 5 bytes.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    wr_en_i = 1'b0; tx_ready_i = 1'b0; clear_ovf_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    chk("rst_valid", int'(tx_valid_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    m_q.delete(); sb_q.delete(); m_ovf = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Random phases that alternate between filling and draining.
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0: begin pw = 70; pr = 30; end
        1: begin pw = 30; pr = 80; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 10; end
      endcase
      r = int'($urandom_range(0, 99));
      step(r < pw, 8'($urandom_range(0, 255)), int'($urandom_range(0, 99)) < pr,
           $urandom_range(0, 15) == 0);
    end
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_left", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
